spi_command_decoder: RTL

SPI_COMMAND_DECODER -- requirements
Module: spi_command_decoder

---
 rtl/spi_command_decoder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/spi_command_decoder.sv
// spi_command_decoder
//   Watches a raw SPI slave-select / clock pair (asynchronous to clock),
//   counts the sclk rising edges inside each ss_n-low frame, and after the
//   frame closes validates the 32-bit word presented by the upstream shift
//   register.
//
//   Frames are rejected when they:
//   - do not carry exactly 32 bits (frame_error is set);
//   - are NOPs (opcode 0), which are silently dropped.
//
//   Good frames go into a 4-deep command FIFO that the sequencer drains
//   with a valid/ready handshake.
//
//   Optional feature: define SPI_PARITY_CHECK_EN to also require odd XOR
//   parity across the whole word; an even-parity word is flagged as a
//   frame error.
//
// Ports
//   clock, reset          system clock, async active-high reset
//   spi_data[31:0]        upstream shift-register word (MSB first in)
//   ss_n, sclk            raw SPI select / clock, asynchronous
//   cmd_valid/cmd_ready   FIFO head handshake
//   cmd_opcode/addr/payload  head word fields [31:28]/[27:24]/[23:0]
//   fifo_count[2:0]       entries held, 0..4
//   frame_error, overflow sticky error flags
//   err_clear             synchronous clear for the sticky flags
module spi_command_decoder (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] spi_data,
  input  logic        ss_n,
  input  logic        sclk,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [3:0]  cmd_opcode,
  output logic [3:0]  cmd_addr,
  output logic [23:0] cmd_payload,
  output logic [2:0]  fifo_count,
  output logic        frame_error,
  output logic        overflow,
  input  logic        err_clear
);

  typedef enum logic [1:0] {IDLE, ACTIVE, SETTLE, COMMIT} state_t;

  // Synchronisers. Bit 0 is the newest sample; edges are decoded from the
  // two older (already metastability-filtered) flops.
  logic [2:0] ss_sync, sclk_sync;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ss_sync   <= 3'b111;
      sclk_sync <= 3'b000;
    end else begin
      ss_sync   <= {ss_sync[1:0], ss_n};
      sclk_sync <= {sclk_sync[1:0], sclk};
    end
  end

  logic ss_fall, ss_rise, sclk_rise;
  assign ss_fall   = (ss_sync[2:1]   == 2'b10);
  assign ss_rise   = (ss_sync[2:1]   == 2'b01);
  assign sclk_rise = (sclk_sync[2:1] == 2'b01);

  // Frame FSM
  state_t     state;
  logic [5:0] bit_cnt;
  logic       settle_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= 6'd0;
      settle_cnt <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ss_fall) begin
            state   <= ACTIVE;
            bit_cnt <= 6'd0;
          end
        end
        ACTIVE: begin
          if (sclk_rise && bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
          if (ss_rise) begin
            state      <= SETTLE;
            settle_cnt <= 1'b0;
          end
        end
        SETTLE: begin
          // Two full cycles here so the final upstream shift is in spi_data.
          if (settle_cnt) state <= COMMIT;
          settle_cnt <= 1'b1;
        end
        default: state <= IDLE;  // COMMIT lasts exactly one cycle
      endcase
    end
  end

  // Commit decision, made on spi_data as it stands in the COMMIT cycle
  logic commit, len_ok, parity_ok, good, push_req;
  assign commit = (state == COMMIT);
  assign len_ok = (bit_cnt == 6'd32);
`ifdef SPI_PARITY_CHECK_EN
  assign parity_ok = ^spi_data;
`else
  assign parity_ok = 1'b1;
`endif
  assign good     = len_ok && parity_ok;
  assign push_req = commit && good && (spi_data[31:28] != 4'd0);

  // Command FIFO
  logic [31:0] mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count;
  logic        pop, push;

  assign cmd_valid = (count != 3'd0);
  assign pop       = cmd_valid && cmd_ready;
  // A full FIFO still takes the word if the head leaves in the same cycle.
  assign push      = push_req && ((count != 3'd4) || pop);

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= spi_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // Sticky flags; a same-cycle set beats err_clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_error <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (commit && !good)  frame_error <= 1'b1;
      else if (err_clear)   frame_error <= 1'b0;
      if (push_req && !push) overflow <= 1'b1;
      else if (err_clear)    overflow <= 1'b0;
    end
  end

  logic [31:0] head;
  assign head        = mem[rd_ptr];
  assign cmd_opcode  = head[31:28];
  assign cmd_addr    = head[27:24];
  assign cmd_payload = head[23:0];
  assign fifo_count  = count;

endmodule
